// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encodings, SPI mode and default timing for spi_master
package spi_master_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam int SPI_MODE     = 3;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_GAP   = 4;
    localparam int TICK_W       = 16;

endpackage

// File: rtl/spi_master_tick_counter.sv
// rtl/spi_master_tick_counter.sv - per-state down-counter; done is high on the last cycle of a state
module spi_tick_counter
    import spi_master_pkg::*;
(
    input  logic              clk_in,
    input  logic              nrst,
    input  logic              load,
    input  logic [TICK_W-1:0] len,
    output logic              done
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    logic [TICK_W-1:0] cnt;

    // Loaded with len-1 on the edge that enters a state, so done marks that state's exit edge.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len - ONE;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-3 MSB-first SPI master, 1..32 bit frames; SPI_LOOPBACK_EN ties internal sdi to spi_sdo
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_GAP   = DEF_CS_GAP
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic [31:0] spi_mosi_data,
    input  logic [4:0]  spi_nbits,
    input  logic        spi_request,
    output logic        spi_ready,
    output logic [31:0] spi_miso_data,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_sdo,
    input  logic        spi_sdi
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [31:0]       tx;
    logic [31:0]       rx;
    logic [4:0]        bitcnt;
    logic              sdi;
    logic              tick_load;
    logic [TICK_W-1:0] tick_len;
    logic              tick_done;

`ifdef SPI_LOOPBACK_EN
    logic unused_sdi;
    assign unused_sdi = spi_sdi;
    assign sdi        = spi_sdo;
`else
    assign sdi = spi_sdi;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (spi_request) state_nxt = ST_SETUP;
            ST_SETUP: if (tick_done)   state_nxt = ST_LOW;
            ST_LOW:   if (tick_done)   state_nxt = ST_HIGH;
            ST_HIGH:  if (tick_done)   state_nxt = (bitcnt == 5'd0) ? ST_HOLD : ST_LOW;
            ST_HOLD:  if (tick_done)   state_nxt = ST_GAP;
            ST_GAP:   if (tick_done)   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_load = (state_nxt != state);
        case (state_nxt)
            ST_SETUP:        tick_len = TICK_W'(CS_SETUP);
            ST_LOW, ST_HIGH: tick_len = TICK_W'(CLK_DIV);
            ST_HOLD:         tick_len = TICK_W'(CS_HOLD);
            ST_GAP:          tick_len = TICK_W'(CS_GAP);
            default:         tick_len = TICK_W'(1);
        endcase
    end

    spi_tick_counter u_tick (
        .clk_in (clk_in),
        .nrst   (nrst),
        .load   (tick_load),
        .len    (tick_len),
        .done   (tick_done)
    );

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state         <= ST_IDLE;
            spi_ready     <= 1'b1;
            spi_miso_data <= '0;
            spi_csn       <= 1'b1;
            spi_sck       <= 1'b1;
            spi_sdo       <= 1'b0;
            tx            <= '0;
            rx            <= '0;
            bitcnt        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (spi_request) begin
                        tx        <= spi_mosi_data;
                        bitcnt    <= spi_nbits;
                        rx        <= '0;
                        spi_ready <= 1'b0;
                        spi_csn   <= 1'b0;
                        spi_sdo   <= spi_mosi_data[spi_nbits];
                    end
                end
                ST_SETUP: begin
                    spi_sdo <= tx[bitcnt];
                    if (tick_done) spi_sck <= 1'b0;
                end
                ST_LOW: begin
                    if (tick_done) begin
                        spi_sck <= 1'b1;
                        rx      <= {rx[30:0], sdi};
                    end
                end
                ST_HIGH: begin
                    // MOSI moves only together with the SCK falling edge.
                    if (tick_done && bitcnt != 5'd0) begin
                        bitcnt  <= bitcnt - 5'd1;
                        spi_sck <= 1'b0;
                        spi_sdo <= tx[bitcnt - 5'd1];
                    end
                end
                ST_HOLD: begin
                    if (tick_done) begin
                        spi_csn       <= 1'b1;
                        spi_miso_data <= rx;
                    end
                end
                ST_GAP: begin
                    if (tick_done) spi_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized and directed bench for spi_master with a mode-3 slave model
module tb_spi_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;

    logic        clk_in = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] spi_mosi_data = '0;
    logic [4:0]  spi_nbits = '0;
    logic        spi_request = 1'b0;
    logic        spi_ready;
    logic [31:0] spi_miso_data;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_sdo;
    logic        spi_sdi = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_master #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk_in        (clk_in),
        .nrst          (nrst),
        .spi_mosi_data (spi_mosi_data),
        .spi_nbits     (spi_nbits),
        .spi_request   (spi_request),
        .spi_ready     (spi_ready),
        .spi_miso_data (spi_miso_data),
        .spi_csn       (spi_csn),
        .spi_sck       (spi_sck),
        .spi_sdo       (spi_sdo),
        .spi_sdi       (spi_sdi)
    );

    always #5 clk_in = ~clk_in;

    // Slave/pin monitor, sampled on the falling clk_in edge.
    logic [31:0] slv_resp = '0;
    int          slv_n = 0;
    int          ncyc = 0;
    int          frames = 0;
    int          rises = 0;
    int          falls = 0;
    logic [31:0] cap = '0;
    int          csn_fall_at = 0;
    int          csn_rise_at = -1;
    int          first_fall_at = -1;
    int          min_gap = 1000;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b1;

    always @(negedge clk_in) begin
        ncyc++;
        if (!spi_csn && prev_csn) begin
            frames++;
            if (csn_rise_at >= 0 && (ncyc - csn_rise_at) < min_gap) min_gap = ncyc - csn_rise_at;
            csn_fall_at   = ncyc;
            first_fall_at = -1;
            rises         = 0;
            falls         = 0;
            cap           = '0;
            spi_sdi       = slv_resp[slv_n];
        end
        if (spi_csn && !prev_csn) csn_rise_at = ncyc;
        if (!spi_csn && prev_sck && !spi_sck) begin
            if (first_fall_at < 0) first_fall_at = ncyc;
            if (falls <= slv_n) spi_sdi = slv_resp[slv_n - falls];
            falls++;
        end
        if (!spi_csn && !prev_sck && spi_sck) begin
            rises++;
            cap = {cap[30:0], spi_sdo};
        end
        prev_csn = spi_csn;
        prev_sck = spi_sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int n);
        logic [63:0] one = 64'd1;
        return 32'((one << (n + 1)) - 64'd1);
    endfunction

    function automatic logic [31:0] exp_miso(input logic [31:0] d, input logic [31:0] r, input int n);
`ifdef SPI_LOOPBACK_EN
        return d & mask_of(n);
`else
        return r & mask_of(n);
`endif
    endfunction

    function automatic int frame_cycles(input int n);
        return 1 + CS_SETUP + 2 * CLK_DIV * (n + 1) + CS_HOLD + CS_GAP;
    endfunction

    task automatic wait_idle(input string tag);
        int k = 0;
        while (spi_ready !== 1'b1 && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 2000) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] d, input int n, input logic [31:0] r);
        int lowcnt = 0;
        wait_idle(tag);
        slv_resp = r;
        slv_n    = n;
        @(negedge clk_in);
        spi_mosi_data = d;
        spi_nbits     = 5'(n);
        spi_request   = 1'b1;
        @(negedge clk_in);
        spi_request   = 1'b0;
        spi_mosi_data = $urandom;
        spi_nbits     = 5'($urandom_range(0, 31));
        while (spi_ready === 1'b0 && lowcnt < 2000) begin
            lowcnt++;
            @(negedge clk_in);
        end
        check({tag, "_miso"}, spi_miso_data, exp_miso(d, r, n));
        check({tag, "_mosi_bits"}, cap, d & mask_of(n));
        check({tag, "_sck_rises"}, 32'(rises), 32'(n + 1));
        check({tag, "_ready_low"}, 32'(lowcnt), 32'(frame_cycles(n) - 1));
        check({tag, "_cs_setup"}, 32'(first_fall_at - csn_fall_at), 32'(CS_SETUP));
    endtask

    initial begin
        int          f0;
        int          k;
        int          tper;
        logic [31:0] d;
        logic [31:0] r;
        int          n;

        #12;
        check("rst_ready", {31'd0, spi_ready}, 32'd1);
        check("rst_miso", spi_miso_data, 32'd0);
        check("rst_csn", {31'd0, spi_csn}, 32'd1);
        check("rst_sck", {31'd0, spi_sck}, 32'd1);
        check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
        @(negedge clk_in);
        nrst = 1'b1;

        run_frame("whoami", 32'h0000_8F00, 15, 32'h0000_0033);
        run_frame("read24", 32'h00E8_0000, 23, 32'h0000_9A12);
        run_frame("lb32", 32'hA5A5_5A5A, 31, 32'h3C3C_C3C3);
        run_frame("lb1", 32'h0000_0001, 0, 32'h0000_0001);
        run_frame("bit0_zero", 32'hFFFF_FFFE, 0, 32'h0000_0000);

        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(0, 31));
            d = $urandom;
            r = $urandom;
            run_frame("rand", d, n, r);
        end

        // Abort after the 5th SCK rise; result of the previous frame must be discarded too.
        run_frame("pre_abort", 32'h1234_5678, 31, 32'hDEAD_BEEF);
        slv_resp = 32'hFFFF_FFFF;
        slv_n    = 15;
        f0 = frames;
        @(negedge clk_in);
        spi_mosi_data = 32'h0000_ABCD;
        spi_nbits     = 5'd15;
        spi_request   = 1'b1;
        @(negedge clk_in);
        spi_request = 1'b0;
        k = 0;
        while ((frames == f0 || rises < 5) && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        check("abort_reach", {31'd0, k < 2000}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("abort_csn", {31'd0, spi_csn}, 32'd1);
        check("abort_sck", {31'd0, spi_sck}, 32'd1);
        check("abort_ready", {31'd0, spi_ready}, 32'd1);
        check("abort_miso", spi_miso_data, 32'd0);
        @(negedge clk_in);
        nrst = 1'b1;
        run_frame("post_abort", 32'hC0FF_EE11, 19, 32'h0005_A5A5);

        // Request held high: back-to-back frames, one every frame_cycles().
        wait_idle("held");
        n = 7;
        slv_resp = 32'h0000_00B7;
        slv_n    = n;
        tper     = frame_cycles(n);
        f0       = frames;
        min_gap  = 1000;
        @(negedge clk_in);
        spi_mosi_data = 32'h0000_0069;
        spi_nbits     = 5'(n);
        spi_request   = 1'b1;
        repeat (300) @(negedge clk_in);
        spi_request = 1'b0;
        wait_idle("held_end");
        repeat (3) @(negedge clk_in);
        check("held_frames", 32'(frames - f0), 32'((300 + tper - 1) / tper));
        check("held_gap_ok", {31'd0, min_gap >= CS_GAP}, 32'd1);
        check("held_miso", spi_miso_data, exp_miso(32'h0000_0069, 32'h0000_00B7, n));

        // Request toggling while busy must not queue a second frame.
        f0 = frames;
        slv_resp = 32'h0000_0C3A;
        slv_n    = 11;
        @(negedge clk_in);
        spi_mosi_data = 32'h0000_0F0F;
        spi_nbits     = 5'd11;
        spi_request   = 1'b1;
        k = 0;
        do begin
            @(negedge clk_in);
            spi_request = (spi_ready === 1'b0) ? 1'($urandom) : 1'b0;
            k++;
        end while (spi_ready !== 1'b1 && k < 2000);
        spi_request = 1'b0;
        repeat (20) @(negedge clk_in);
        check("toggle_frames", 32'(frames - f0), 32'd1);
        check("toggle_miso", spi_miso_data, exp_miso(32'h0000_0F0F, 32'h0000_0C3A, 11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
